// File: rtl/gin_pkg.sv
// Shared constants and helpers for the global input network.
package gin_pkg;

    localparam int XBUS_NUMS_DEF = 12;
    localparam int PE_NUMS_DEF   = 14;
    localparam int ID_LEN_DEF    = 5;
    localparam int ROW_LEN_DEF   = 4;
    localparam int VALUE_LEN_DEF = 8;

    // All-ones marks a register as unmapped; it never matches any tag.
    localparam logic [ROW_LEN_DEF-1:0] UNMAPPED_ROW = '1;
    localparam logic [ID_LEN_DEF-1:0]  UNMAPPED_ID  = '1;

    // Flat PE index used for the ID chain, pe_ready and pe_enable_data.
    function automatic int pe_index(input int bus, input int pe, input int pe_nums);
        return bus * pe_nums + pe;
    endfunction

endpackage

// File: rtl/gin_xbus.sv
// One horizontal bus: row compare, per-PE ID compare, local ready-AND
// and enable gating from the global ready.
module gin_xbus #(
    parameter int PE_NUMS = 14,
    parameter int ID_LEN  = 5,
    parameter int ROW_LEN = 4
) (
    input  logic [ROW_LEN-1:0]         row_reg,
    input  logic [PE_NUMS*ID_LEN-1:0]  id_reg,
    input  logic [ROW_LEN-1:0]         row_tag,
    input  logic [ID_LEN-1:0]          col_tag,
    input  logic                       enable,
    input  logic [PE_NUMS-1:0]         pe_ready,
    input  logic                       ready,
    output logic                       bus_ok,
    output logic [PE_NUMS-1:0]         pe_en
);

    logic               row_hit;
    logic [PE_NUMS-1:0] match;

    // Match each PE against the tag; unmapped (all-ones) registers never hit.
    always_comb begin
        row_hit = enable && (row_reg == row_tag) && (row_reg != {ROW_LEN{1'b1}});
        match   = '0;
        for (int p = 0; p < PE_NUMS; p++) begin
            match[p] = row_hit
                && (id_reg[p*ID_LEN +: ID_LEN] == col_tag)
                && (id_reg[p*ID_LEN +: ID_LEN] != {ID_LEN{1'b1}});
        end
    end

    // A bus blocks the transfer only if one of its targets is not ready.
    assign bus_ok = &(~match | pe_ready);
    assign pe_en  = match & {PE_NUMS{ready}};

endmodule

// File: rtl/global_input_network.sv
// Global input network: row/ID scan chains, per-bus match logic and an
// atomic multicast handshake to the PE array.
module global_input_network
    import gin_pkg::*;
#(
    parameter int XBUS_NUMS = XBUS_NUMS_DEF,
    parameter int PE_NUMS   = PE_NUMS_DEF,
    parameter int ID_LEN    = ID_LEN_DEF,
    parameter int ROW_LEN   = ROW_LEN_DEF,
    parameter int VALUE_LEN = VALUE_LEN_DEF
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      enable,
    output logic                                      ready,
    input  logic [ROW_LEN-1:0]                        row_tag,
    input  logic [ID_LEN-1:0]                         col_tag,
    input  logic [VALUE_LEN-1:0]                      value,
    input  logic                                      set_row,
    input  logic [ROW_LEN-1:0]                        row_scan_in,
    output logic [ROW_LEN-1:0]                        row_scan_out,
    input  logic                                      set_id,
    input  logic [ID_LEN-1:0]                         id_scan_in,
    output logic [ID_LEN-1:0]                         id_scan_out,
    input  logic [XBUS_NUMS*PE_NUMS-1:0]              pe_ready,
    output logic [(VALUE_LEN+1)*XBUS_NUMS*PE_NUMS-1:0] pe_enable_data
);

    localparam int NPE = XBUS_NUMS * PE_NUMS;

    logic [XBUS_NUMS*ROW_LEN-1:0] row_q, row_d;
    logic [NPE*ID_LEN-1:0]        id_q, id_d;
    logic [XBUS_NUMS-1:0]         bus_ok;
    logic [NPE-1:0]               pe_en;
    logic                         cfg_busy;

    // Scan chains: element 0 sits in the LSBs and takes the scan input.
    always_comb begin
        row_d = row_q;
        id_d  = id_q;
        if (set_row) row_d = {row_q[(XBUS_NUMS-1)*ROW_LEN-1:0], row_scan_in};
        if (set_id)  id_d  = {id_q[(NPE-1)*ID_LEN-1:0], id_scan_in};
    end

    // Config registers reset to unmapped so nothing matches until loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '1;
            id_q  <= '1;
        end else begin
            row_q <= row_d;
            id_q  <= id_d;
        end
    end

    assign row_scan_out = row_q[XBUS_NUMS*ROW_LEN-1 -: ROW_LEN];
    assign id_scan_out  = id_q[NPE*ID_LEN-1 -: ID_LEN];

    // Config shifts take priority over data; reset also holds ready low.
    assign cfg_busy = set_row | set_id;
    assign ready    = enable & rst & ~cfg_busy & (&bus_ok);

    for (genvar b = 0; b < XBUS_NUMS; b++) begin : g_xbus
        localparam int BASE = pe_index(b, 0, PE_NUMS);
        gin_xbus #(
            .PE_NUMS (PE_NUMS),
            .ID_LEN  (ID_LEN),
            .ROW_LEN (ROW_LEN)
        ) u_xbus (
            .row_reg  (row_q[b*ROW_LEN +: ROW_LEN]),
            .id_reg   (id_q[BASE*ID_LEN +: PE_NUMS*ID_LEN]),
            .row_tag  (row_tag),
            .col_tag  (col_tag),
            .enable   (enable),
            .pe_ready (pe_ready[BASE +: PE_NUMS]),
            .ready    (ready),
            .bus_ok   (bus_ok[b]),
            .pe_en    (pe_en[BASE +: PE_NUMS])
        );
    end

    // Pack enable bit above the broadcast data word for every PE.
    always_comb begin
        pe_enable_data = '0;
        for (int k = 0; k < NPE; k++) begin
            pe_enable_data[k*(VALUE_LEN+1) +: VALUE_LEN+1] = {pe_en[k], value};
        end
    end

endmodule

// File: tb/tb_global_input_network.sv
// Self-checking bench for global_input_network.
module tb_global_input_network;

    localparam int XB = 12, PE = 14, IDL = 5, RL = 4, VL = 8;
    localparam int N  = XB * PE;
    localparam int DW = VL + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            ready;
    logic [RL-1:0]   row_tag;
    logic [IDL-1:0]  col_tag;
    logic [VL-1:0]   value;
    logic            set_row;
    logic [RL-1:0]   row_scan_in;
    logic [RL-1:0]   row_scan_out;
    logic            set_id;
    logic [IDL-1:0]  id_scan_in;
    logic [IDL-1:0]  id_scan_out;
    logic [N-1:0]    pe_ready;
    logic [N*DW-1:0] pe_enable_data;

    int n_checks = 0;
    int n_errors = 0;

    global_input_network dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .ready          (ready),
        .row_tag        (row_tag),
        .col_tag        (col_tag),
        .value          (value),
        .set_row        (set_row),
        .row_scan_in    (row_scan_in),
        .row_scan_out   (row_scan_out),
        .set_id         (set_id),
        .id_scan_in     (id_scan_in),
        .id_scan_out    (id_scan_out),
        .pe_ready       (pe_ready),
        .pe_enable_data (pe_enable_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           enable;
        logic           set_id;
        logic [RL-1:0]  row_tag;
        logic [IDL-1:0] col_tag;
        logic [VL-1:0]  value;
        int             nrdy;
        logic           exp_ready;
        int             exp_a;
        int             exp_b;
    } vec_t;

    typedef struct {
        int            tag;
        logic          ready;
        logic [N*DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    logic [RL-1:0]  cfg_row[XB];
    logic [IDL-1:0] cfg_id[N];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one transfer and push its expected response to the scoreboard.
    task automatic drive(input int tag, input vec_t v);
        exp_t e;
        enable   = v.enable;
        set_id   = v.set_id;
        row_tag  = v.row_tag;
        col_tag  = v.col_tag;
        value    = v.value;
        pe_ready = '1;
        if (v.nrdy >= 0) pe_ready[v.nrdy] = 1'b0;
        e.tag   = tag;
        e.ready = v.exp_ready;
        for (int k = 0; k < N; k++)
            e.data[k*DW +: DW] = {(k == v.exp_a) || (k == v.exp_b), v.value};
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare at the falling edge.
    task automatic check_out();
        exp_t e;
        int   first;
        @(negedge clk);
        e = sb.pop_front();
        check($sformatf("vec%0d ready", e.tag), {31'd0, ready}, {31'd0, e.ready});
        n_checks++;
        if (pe_enable_data !== e.data) begin
            n_errors++;
            first = -1;
            for (int k = N - 1; k >= 0; k--)
                if (pe_enable_data[k*DW +: DW] !== e.data[k*DW +: DW]) first = k;
            $display("FAIL vec%0d pe_enable_data[%0d]: got %h expected %h", e.tag, first,
                     pe_enable_data[first*DW +: DW], e.data[first*DW +: DW]);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic sid, input logic [RL-1:0] rt,
                                input logic [IDL-1:0] ct, input logic [VL-1:0] val,
                                input int nrdy, input logic er, input int a, input int b);
        vec_t v;
        v.enable = en; v.set_id = sid; v.row_tag = rt; v.col_tag = ct; v.value = val;
        v.nrdy = nrdy; v.exp_ready = er; v.exp_a = a; v.exp_b = b;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [IDL-1:0] kid;

        for (int b = 0; b < XB; b++) cfg_row[b] = RL'(b);
        cfg_row[1] = 4'd3;
        cfg_row[3] = 4'd1;
        for (int k = 0; k < N; k++) cfg_id[k] = 5'h1F;
        cfg_id[2]  = 5'd7;
        cfg_id[44] = 5'd7;
        cfg_id[51] = 5'd7;
        cfg_id[74] = 5'd12;
        cfg_id[14] = 5'd30;

        vecs[0] = mk(1, 0, 4'd1, 5'd7,  8'hA5, -1, 1, 44, 51);
        vecs[1] = mk(1, 0, 4'd1, 5'd7,  8'hA5, 51, 0, -1, -1);
        vecs[2] = mk(1, 0, 4'd1, 5'd7,  8'hA5, -1, 1, 44, 51);
        vecs[3] = mk(1, 0, 4'd5, 5'd30, 8'h3C, -1, 1, -1, -1);
        vecs[4] = mk(0, 0, 4'd1, 5'd7,  8'h5A, -1, 0, -1, -1);
        vecs[5] = mk(1, 0, 4'd5, 5'd12, 8'h81, 44, 1, 74, -1);
        vecs[6] = mk(1, 0, 4'd3, 5'd30, 8'h0F, -1, 1, 14, -1);
        vecs[7] = mk(1, 0, 4'd1, 5'd31, 8'hFF, -1, 1, -1, -1);
        vecs[8] = mk(1, 0, 4'd1, 5'd7,  8'h66, 44, 0, -1, -1);
        vecs[9] = mk(1, 1, 4'd1, 5'd7,  8'hC3, -1, 0, -1, -1);

        rst = 1'b0; enable = 0; row_tag = '0; col_tag = '0; value = '0;
        set_row = 0; row_scan_in = '0; set_id = 0; id_scan_in = '0; pe_ready = '1;

        // Reset state
        @(negedge clk);
        enable = 1'b1; row_tag = 4'hF; col_tag = 5'h1F;
        #1;
        check("reset ready", {31'd0, ready}, 32'd0);
        check("reset row_scan_out", {28'd0, row_scan_out}, 32'hF);
        check("reset id_scan_out", {27'd0, id_scan_out}, 32'h1F);
        enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Row chain readback, then load the working row map
        for (int j = 0; j < XB; j++) begin
            set_row = 1'b1; row_scan_in = RL'(j);
            @(posedge clk); #1;
        end
        for (int j = 0; j < XB; j++) begin
            check($sformatf("row readback %0d", j), {28'd0, row_scan_out}, j);
            row_scan_in = cfg_row[XB-1-j];
            @(posedge clk); #1;
        end
        set_row = 1'b0;

        // ID chain readback, then load the working ID map
        for (int k = 0; k < N; k++) begin
            set_id = 1'b1; id_scan_in = IDL'(k % 32);
            @(posedge clk); #1;
        end
        for (int k = 0; k < N; k++) begin
            kid = IDL'(k % 32);
            check($sformatf("id readback %0d", k), {27'd0, id_scan_out}, {27'd0, kid});
            id_scan_in = cfg_id[N-1-k];
            @(posedge clk); #1;
        end
        set_id = 1'b0;

        // Data vectors: multicast, backpressure, no-match, config priority
        for (int i = 0; i < 10; i++) begin
            drive(i, vecs[i]);
            check_out();
            @(posedge clk); #1;
        end
        set_id = 1'b0;

        // Reset after configuration drops every mapping at once
        rst = 1'b0;
        drive(10, mk(1, 0, 4'd1, 5'd7, 8'h11, -1, 0, -1, -1));
        check_out();
        check("post-config reset row_scan_out", {28'd0, row_scan_out}, 32'hF);
        check("post-config reset id_scan_out", {27'd0, id_scan_out}, 32'h1F);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(11, mk(1, 0, 4'd1, 5'd7, 8'h22, -1, 1, -1, -1));
        check_out();
        @(posedge clk); #1;
        drive(12, mk(1, 0, 4'd15, 5'd31, 8'h33, -1, 1, -1, -1));
        check_out();
        @(posedge clk); #1;
        enable = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
